// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I-subset controller:
// state codes shown on the LCD, opcodes, ALU operations and datapath selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_WAIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXECR  = 4'd7,
      S_EXECI  = 4'd8,
      S_ALUWB  = 4'd9,
      S_BEQ    = 4'd10,
      S_HALT   = 4'd11
   } state_e;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLDPC  = 2'b01;
   localparam logic [1:0] SRCA_RS1    = 2'b10;
   localparam logic [1:0] SRCB_RS2    = 2'b00;
   localparam logic [1:0] SRCB_IMM    = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_RDATA   = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   // States in which an instruction retires.
   function automatic logic is_terminal(input state_e s);
      logic t;
      case (s)
         S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ: t = 1'b1;
         default:                          t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bus: decoded instruction/flag in, strobes and selects out.
interface multicycle_ctrl_if #(
   parameter int NINSTR_BITS = 32
);
   logic [NINSTR_BITS-1:0] instr;
   logic                   zero;
   logic                   pc_write;
   logic                   ir_write;
   logic                   adr_src;
   logic                   mem_write;
   logic                   reg_write;
   logic                   branch;
   logic [1:0]             alu_src_a;
   logic [1:0]             alu_src_b;
   logic [1:0]             result_src;
   logic [2:0]             alu_control;

   modport master (
      input  instr, zero,
      output pc_write, ir_write, adr_src, mem_write, reg_write, branch,
             alu_src_a, alu_src_b, result_src, alu_control
   );

   modport slave (
      output instr, zero,
      input  pc_write, ir_write, adr_src, mem_write, reg_write, branch,
             alu_src_a, alu_src_b, result_src, alu_control
   );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from funct3/funct7[5]; flags funct3
// values the ALU cannot execute on R-type and I-ALU opcodes.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output alu_ctrl_e  alu_control,
   output logic       illegal
);

   // funct3 to ALU op; funct7[5] selects sub only on register-register ops
   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      case (funct3)
         3'b000: begin
            if (is_rtype && funct7_5) begin
               alu_control = ALU_SUB;
            end else begin
               alu_control = ALU_ADD;
            end
         end
         3'b010: alu_control = ALU_SLT;
         3'b110: alu_control = ALU_OR;
         3'b111: alu_control = ALU_AND;
         default: begin
            alu_control = ALU_ADD;
            illegal     = (opcode == OP_R) || (opcode == OP_I);
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath sequencer with run/single-step control, a sticky halt on
// illegal instructions and a wrapping retired-instruction counter for the LCD.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int NINSTR_BITS = 32,
   parameter int NCOUNT_BITS = 8
) (
   input  logic                   clk_2,
   input  logic                   reset_n,
   input  logic                   run,
   input  logic                   step,
   multicycle_ctrl_if.master      bus,
   output logic [3:0]             state,
   output logic                   instr_done,
   output logic                   halted,
   output logic [NCOUNT_BITS-1:0] instr_count
);

   state_e                 state_r;
   state_e                 state_nx_s;
   logic                   step_q_r;
   logic                   step_pulse_s;
   logic [NCOUNT_BITS-1:0] count_r;
   logic [6:0]             opcode_s;
   alu_ctrl_e              dec_alu_s;
   logic                   dec_illegal_s;
   logic                   unused_instr_s;

   assign opcode_s       = bus.instr[6:0];
   assign unused_instr_s = ^{bus.instr[NINSTR_BITS-1:31], bus.instr[29:15], bus.instr[11:7]};
   assign step_pulse_s   = step & ~step_q_r;

   alu_decoder u_alu_decoder (
      .opcode      (opcode_s),
      .funct3      (bus.instr[14:12]),
      .funct7_5    (bus.instr[30]),
      .is_rtype    (opcode_s == OP_R),
      .alu_control (dec_alu_s),
      .illegal     (dec_illegal_s)
   );

   // State register and step-switch history
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= S_WAIT;
         step_q_r <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         step_q_r <= step;
      end
   end

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {NCOUNT_BITS{1'b0}};
      end else if (is_terminal(state_r)) begin
         count_r <= count_r + {{(NCOUNT_BITS-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   // Next-state logic; run is sampled only in WAIT and terminal states
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_WAIT: begin
            if (run || step_pulse_s) begin
               state_nx_s = S_FETCH;
            end else begin
               state_nx_s = S_WAIT;
            end
         end
         S_FETCH:  state_nx_s = S_DECODE;
         S_DECODE: begin
            case (opcode_s)
               OP_LW, OP_SW: state_nx_s = S_MEMADR;
               OP_R:         state_nx_s = dec_illegal_s ? S_HALT : S_EXECR;
               OP_I:         state_nx_s = dec_illegal_s ? S_HALT : S_EXECI;
               OP_BEQ:       state_nx_s = S_BEQ;
               default:      state_nx_s = S_HALT;
            endcase
         end
         S_MEMADR: begin
            if (opcode_s == OP_SW) begin
               state_nx_s = S_MEMWR;
            end else begin
               state_nx_s = S_MEMRD;
            end
         end
         S_MEMRD:          state_nx_s = S_MEMWB;
         S_EXECR, S_EXECI: state_nx_s = S_ALUWB;
         S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ: begin
            if (run) begin
               state_nx_s = S_FETCH;
            end else begin
               state_nx_s = S_WAIT;
            end
         end
         S_HALT:  state_nx_s = S_HALT;
         default: state_nx_s = S_WAIT;
      endcase
   end

   // Moore output decode; only the BEQ pc_write follows zero directly
   always_comb begin
      bus.pc_write    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.adr_src     = 1'b0;
      bus.mem_write   = 1'b0;
      bus.reg_write   = 1'b0;
      bus.branch      = 1'b0;
      bus.alu_src_a   = SRCA_PC;
      bus.alu_src_b   = SRCB_RS2;
      bus.result_src  = RES_ALUOUT;
      bus.alu_control = ALU_ADD;
      case (state_r)
         S_FETCH: begin
            bus.ir_write   = 1'b1;
            bus.pc_write   = 1'b1;
            bus.alu_src_a  = SRCA_PC;
            bus.alu_src_b  = SRCB_FOUR;
            bus.result_src = RES_ALU;
         end
         S_DECODE: begin
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: bus.adr_src = 1'b1;
         S_MEMWB: begin
            bus.result_src = RES_RDATA;
            bus.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            bus.adr_src   = 1'b1;
            bus.mem_write = 1'b1;
         end
         S_EXECR: begin
            bus.alu_src_a   = SRCA_RS1;
            bus.alu_src_b   = SRCB_RS2;
            bus.alu_control = dec_alu_s;
         end
         S_EXECI: begin
            bus.alu_src_a   = SRCA_RS1;
            bus.alu_src_b   = SRCB_IMM;
            bus.alu_control = dec_alu_s;
         end
         S_ALUWB: bus.reg_write = 1'b1;
         S_BEQ: begin
            bus.alu_src_a   = SRCA_RS1;
            bus.alu_src_b   = SRCB_RS2;
            bus.alu_control = ALU_SUB;
            bus.branch      = 1'b1;
            bus.pc_write    = bus.zero;
         end
         default: bus.pc_write = 1'b0;
      endcase
   end

   assign state       = state_r;
   assign instr_done  = is_terminal(state_r);
   assign halted      = (state_r == S_HALT);
   assign instr_count = count_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction
// state-path and per-state output model derived from the controller's rules.
module tb_multicycle_ctrl;

   logic       clk_2 = 1'b0;
   logic       reset_n;
   logic       run;
   logic       step;
   logic [3:0] state;
   logic       instr_done;
   logic       halted;
   logic [7:0] instr_count;

   multicycle_ctrl_if #(.NINSTR_BITS(32)) bus ();

   multicycle_ctrl #(.NINSTR_BITS(32), .NCOUNT_BITS(8)) dut (
      .clk_2       (clk_2),
      .reset_n     (reset_n),
      .run         (run),
      .step        (step),
      .bus         (bus),
      .state       (state),
      .instr_done  (instr_done),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clk_2 = ~clk_2;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_count;
   int         path_q[$];

   // Observed outputs packed in the same order the model produces them
   logic [16:0] act_out;
   assign act_out = {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_write,
                     bus.reg_write, bus.branch, bus.alu_src_a, bus.alu_src_b,
                     bus.result_src, bus.alu_control, instr_done, halted};

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   function automatic logic [2:0] exp_alu(input logic [31:0] ins);
      logic [2:0] a;
      case (ins[14:12])
         3'd0:    a = ((ins[6:0] == 7'b0110011) && ins[30]) ? 3'b001 : 3'b000;
         3'd2:    a = 3'b101;
         3'd6:    a = 3'b011;
         3'd7:    a = 3'b010;
         default: a = 3'b000;
      endcase
      return a;
   endfunction

   // Sequence of state codes an instruction visits, FETCH through its last state
   function automatic void build_path(input logic [31:0] ins);
      path_q.delete();
      path_q.push_back(1);
      path_q.push_back(2);
      case (ins[6:0])
         7'b0000011: begin path_q.push_back(3); path_q.push_back(4); path_q.push_back(5); end
         7'b0100011: begin path_q.push_back(3); path_q.push_back(6); end
         7'b0110011: begin
            if (f3_legal(ins[14:12])) begin path_q.push_back(7); path_q.push_back(9); end
            else path_q.push_back(11);
         end
         7'b0010011: begin
            if (f3_legal(ins[14:12])) begin path_q.push_back(8); path_q.push_back(9); end
            else path_q.push_back(11);
         end
         7'b1100011: path_q.push_back(10);
         default:    path_q.push_back(11);
      endcase
   endfunction

   function automatic logic [16:0] exp_out(input int st, input logic [31:0] ins, input logic z);
      logic pcw, irw, adr, mw, rw, br, done, hlt;
      logic [1:0] sa, sb, rs;
      logic [2:0] alu;
      {pcw, irw, adr, mw, rw, br, done, hlt} = 8'd0;
      sa = 2'd0; sb = 2'd0; rs = 2'd0; alu = 3'd0;
      case (st)
         1:  begin pcw = 1'b1; irw = 1'b1; sb = 2'd2; rs = 2'd2; end
         2:  begin sa = 2'd1; sb = 2'd1; end
         3:  begin sa = 2'd2; sb = 2'd1; end
         4:  adr = 1'b1;
         5:  begin rs = 2'd1; rw = 1'b1; done = 1'b1; end
         6:  begin adr = 1'b1; mw = 1'b1; done = 1'b1; end
         7:  begin sa = 2'd2; sb = 2'd0; alu = exp_alu(ins); end
         8:  begin sa = 2'd2; sb = 2'd1; alu = exp_alu(ins); end
         9:  begin rw = 1'b1; done = 1'b1; end
         10: begin sa = 2'd2; alu = 3'b001; br = 1'b1; pcw = z; done = 1'b1; end
         11: hlt = 1'b1;
         default: ;
      endcase
      return {pcw, irw, adr, mw, rw, br, sa, sb, rs, alu, done, hlt};
   endfunction

   function automatic logic retires(input int st);
      return (st == 5) || (st == 6) || (st == 9) || (st == 10);
   endfunction

   // One whole instruction, entered from WAIT(run=1) or a terminal state
   task automatic test_instr(input string name, input logic [31:0] ins, input logic z);
      bus.instr = ins;
      bus.zero  = z;
      build_path(ins);
      for (int i = 0; i < path_q.size(); i++) begin
         @(posedge clk_2); #1;
         n_checks++;
         if (state !== 4'(path_q[i])) $display("FAIL %s state cyc%0d: got %0d want %0d", name, i, state, path_q[i]);
         else n_pass++;
         n_checks++;
         if (act_out !== exp_out(path_q[i], ins, z)) $display("FAIL %s outputs cyc%0d: got %h want %h", name, i, act_out, exp_out(path_q[i], ins, z));
         else n_pass++;
         n_checks++;
         if (instr_count !== exp_count) $display("FAIL %s count cyc%0d: got %0d want %0d", name, i, instr_count, exp_count);
         else n_pass++;
         if (retires(path_q[i])) exp_count = exp_count + 8'd1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; run = 1'b0; step = 1'b0; bus.instr = 32'd0; bus.zero = 1'b0;
      exp_count = 8'd0;
      #2;
      n_checks++;
      if (state !== 4'd0 || act_out !== 17'd0 || instr_count !== 8'd0)
         $display("FAIL reset_async: got state=%0d out=%h cnt=%0d want 0/0/0", state, act_out, instr_count);
      else n_pass++;
      @(posedge clk_2); #1;
      n_checks++;
      if (state !== 4'd0) $display("FAIL reset_hold: got state=%0d want 0", state);
      else n_pass++;
      @(negedge clk_2);
      reset_n = 1'b1;
      run     = 1'b1;
   endtask

   task automatic test_alu_ops();
      test_instr("add", 32'h002081B3, 1'b0);
      test_instr("sub", 32'h402081B3, 1'b1);
      test_instr("ori", 32'h0050E093, 1'b0);
      test_instr("slt", 32'h0020A1B3, 1'b0);
   endtask

   task automatic test_mem();
      test_instr("lw", 32'h00402283, 1'b0);
      test_instr("sw", 32'h00502423, 1'b1);
   endtask

   task automatic test_branch();
      test_instr("beq_taken", 32'h00000463, 1'b1);
      test_instr("beq_not_taken", 32'h00000463, 1'b0);
   endtask

   // Dropping run mid-instruction: it completes, then parks in WAIT
   task automatic test_run_change();
      bus.instr = 32'h002081B3;
      build_path(32'h002081B3);
      for (int i = 0; i < path_q.size(); i++) begin
         @(posedge clk_2); #1;
         if (i == 1) run = 1'b0;
         n_checks++;
         if (state !== 4'(path_q[i])) $display("FAIL run_change state cyc%0d: got %0d want %0d", i, state, path_q[i]);
         else n_pass++;
         if (retires(path_q[i])) exp_count = exp_count + 8'd1;
      end
      @(posedge clk_2); #1;
      n_checks++;
      if (state !== 4'd0 || instr_count !== exp_count)
         $display("FAIL run_change park: got state=%0d cnt=%0d want 0/%0d", state, instr_count, exp_count);
      else n_pass++;
   endtask

   task automatic test_step();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_2); #1;
         n_checks++;
         if (state !== 4'd0) $display("FAIL step_idle cyc%0d: got %0d want 0", i, state);
         else n_pass++;
      end
      bus.instr = 32'h002081B3;
      build_path(32'h002081B3);
      step = 1'b1;
      for (int i = 0; i < path_q.size(); i++) begin
         @(posedge clk_2); #1;
         if (i == 0) step = 1'b0;
         if (i == 1) step = 1'b1;
         n_checks++;
         if (state !== 4'(path_q[i])) $display("FAIL step_instr state cyc%0d: got %0d want %0d", i, state, path_q[i]);
         else n_pass++;
         if (retires(path_q[i])) exp_count = exp_count + 8'd1;
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_2); #1;
         n_checks++;
         if (state !== 4'd0 || instr_count !== exp_count)
            $display("FAIL step_after cyc%0d: got state=%0d cnt=%0d want 0/%0d", i, state, instr_count, exp_count);
         else n_pass++;
      end
      step = 1'b0;
   endtask

   task automatic pulse_reset(input string name);
      #2 reset_n = 1'b0;
      #1;
      exp_count = 8'd0;
      n_checks++;
      if (state !== 4'd0 || halted !== 1'b0 || instr_count !== 8'd0 || act_out !== 17'd0)
         $display("FAIL %s: got state=%0d halted=%b cnt=%0d out=%h want 0/0/0/0", name, state, halted, instr_count, act_out);
      else n_pass++;
      @(negedge clk_2);
      reset_n = 1'b1;
   endtask

   task automatic test_halt();
      run = 1'b1;
      test_instr("bad_opcode", 32'h0000007F, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_2); #1;
         n_checks++;
         if (state !== 4'd11 || act_out !== 17'd1) $display("FAIL halt_sticky cyc%0d: got state=%0d out=%h want 11/00001", i, state, act_out);
         else n_pass++;
      end
      pulse_reset("halt_reset");
      test_instr("bad_funct3", 32'h002091B3, 1'b0);
      pulse_reset("halt_reset2");
      // Abort an add in EXECR; the count must not advance
      bus.instr = 32'h002081B3;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_2); #1;
      end
      n_checks++;
      if (state !== 4'd7) $display("FAIL abort_setup: got state=%0d want 7", state);
      else n_pass++;
      pulse_reset("abort_reset");
   endtask

   task automatic test_random();
      logic [2:0] legal [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
      logic [31:0] ins;
      for (int n = 0; n < 300; n++) begin
         ins = $urandom;
         case ($urandom_range(0, 4))
            0: begin ins[6:0] = 7'b0000011; ins[14:12] = 3'd2; end
            1: begin ins[6:0] = 7'b0100011; ins[14:12] = 3'd2; end
            2: begin ins[6:0] = 7'b0110011; ins[14:12] = legal[$urandom_range(0, 3)]; end
            3: begin ins[6:0] = 7'b0010011; ins[14:12] = legal[$urandom_range(0, 3)]; end
            default: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'd0; end
         endcase
         test_instr("random", ins, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_mem();
      test_branch();
      test_run_change();
      test_step();
      test_halt();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
